// File: rtl/keypad_cmd.sv
// keypad_cmd: scans a 4x4 active-low keypad, debounces,
// and emits one calculator command per press.
module keypad_cmd #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3,
  parameter int HOLD     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cols,
  input  logic [1:0] status,
  output logic [3:0] rows,
  output logic [3:0] cmd
);

  localparam logic [7:0] DIV_LAST  = 8'(SCAN_DIV - 1);
  localparam logic [7:0] DB_N      = 8'(DEBOUNCE);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [3:0] CMD_IDLE  = 4'hF;
  localparam logic [1:0] ST_BUSY   = 2'b01;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCING,
    WAIT_READY,
    SEND,
    RELEASE
  } state_t;

  // Key D maps to CMD_IDLE, which doubles as "no command".
  function automatic logic [3:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] code;
    unique case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hD;
      4'hD: code = 4'h0;
      4'hE: code = 4'hE;
      4'hF: code = CMD_IDLE;
    endcase
    return code;
  endfunction

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [3:0] rows_q, rows_d;
  logic [3:0] cmd_q, cmd_d;
  state_t     state_q, state_d;

  logic       sample;
  logic       col_hit;
  logic [1:0] col_idx;
  state_t     acc_state;

  // Synchronizer and free-running row dwell counter.
  always_comb begin
    sync1_d = cols;
    sync2_d = sync1_q;
    sample  = (dwell_q == DIV_LAST);
    dwell_d = sample ? 8'd0 : dwell_q + 8'd1;
  end

  // Detect exactly one low column in the synced sample.
  always_comb begin
    col_hit = 1'b1;
    col_idx = 2'd0;
    unique case (sync2_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_hit = 1'b0;
    endcase
    acc_state = (key_code(row_q, col_idx) == CMD_IDLE)
              ? RELEASE : WAIT_READY;
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    cmd_d   = CMD_IDLE;
    unique case (state_q)
      SCAN: begin
        if (sample) begin
          if (col_hit) begin
            col_d = col_idx;
            if (DB_N == 8'd1) begin
              cnt_d   = 8'd0;
              state_d = acc_state;
            end else begin
              cnt_d   = 8'd1;
              state_d = DEBOUNCING;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      DEBOUNCING: begin
        if (sample) begin
          if (col_hit && col_idx == col_q) begin
            if (cnt_q + 8'd1 == DB_N) begin
              cnt_d   = 8'd0;
              state_d = acc_state;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d   = 8'd0;
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end
        end
      end
      WAIT_READY: begin
        if (status != ST_BUSY) begin
          hold_d  = 8'd0;
          cmd_d   = key_code(row_q, col_q);
          state_d = SEND;
        end
      end
      SEND: begin
        if (hold_q == HOLD_LAST) begin
          cnt_d   = 8'd0;
          state_d = RELEASE;
        end else begin
          hold_d = hold_q + 8'd1;
          cmd_d  = key_code(row_q, col_q);
        end
      end
      RELEASE: begin
        if (sample) begin
          if (sync2_q == 4'hF) begin
            if (cnt_q + 8'd1 == DB_N) begin
              cnt_d   = 8'd0;
              row_d   = row_q + 2'd1;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d = 8'd0;
          end
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = SCAN;
      end
    endcase
    rows_d = ~(4'b0001 << row_d);
  end

  // State and output registers, async active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      dwell_q <= 8'd0;
      cnt_q   <= 8'd0;
      hold_q  <= 8'd0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      rows_q  <= 4'b1110;
      cmd_q   <= CMD_IDLE;
      state_q <= SCAN;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      cmd_q   <= cmd_d;
      state_q <= state_d;
    end
  end

  assign rows = rows_q;
  assign cmd  = cmd_q;

endmodule

// File: tb/tb_keypad_cmd.sv
// tb_keypad_cmd: keypad model plus pulse monitor,
// randomized presses checked against the key table.
module tb_keypad_cmd;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int HOLD     = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] cols;
  logic [1:0] status;
  logic [3:0] rows;
  logic [3:0] cmd;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] code;
    int         len;
    int         start;
  } pulse_t;

  pulse_t     obs[$];
  int         run = 0;
  int         run_start = 0;
  logic [3:0] run_code = 4'hF;
  int         glitch = 0;
  logic [3:0] keymap [16];

  keypad_cmd #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE),
    .HOLD(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cols(cols),
    .status(status),
    .rows(rows),
    .cmd(cmd)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Passive matrix: a pressed key pulls its column low
  // while its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  // Collect every non-idle run on cmd as one pulse.
  always @(negedge clock) begin
    if (reset) begin
      run = 0;
    end else if (cmd !== 4'hF) begin
      if (run == 0) begin
        run_start = cyc;
        run_code  = cmd;
      end else if (cmd !== run_code) begin
        glitch++;
      end
      run++;
    end else if (run != 0) begin
      obs.push_back('{code: run_code, len: run,
                      start: run_start});
      run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pressed = '0;
    status = 2'b00;
    tick(3);
    checks++;
    if (rows !== 4'b1110) begin
      errors++;
      $display("FAIL reset_rows got %b want 1110", rows);
    end
    checks++;
    if (cmd !== 4'hF) begin
      errors++;
      $display("FAIL reset_cmd got %h want f", cmd);
    end
    reset = 1'b0;
    tick(SCAN_DIV - 1);
    checks++;
    if (rows !== 4'b1110) begin
      errors++;
      $display("FAIL row0_dwell got %b want 1110", rows);
    end
    tick(1);
    checks++;
    if (rows !== 4'b1101) begin
      errors++;
      $display("FAIL row1_step got %b want 1101", rows);
    end
    checks++;
    if (cmd !== 4'hF) begin
      errors++;
      $display("FAIL idle_cmd got %h want f", cmd);
    end
  endtask

  task automatic test_single_press();
    logic [3:0] prev;
    bit found = 0;
    int t0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = rows;
      @(negedge clock);
      if (rows == 4'b1101 && prev != 4'b1101) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL row1_wait got timeout want 1101");
    end
    t0 = cyc;
    obs.delete();
    glitch = 0;
    pressed[5] = 1'b1;
    tick(200);
    pressed[5] = 1'b0;
    tick(60);
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL single_count got %0d want 1",
               obs.size());
    end
    if (obs.size() >= 1) begin
      checks++;
      if (obs[0].code !== 4'h5) begin
        errors++;
        $display("FAIL single_code got %h want 5",
                 obs[0].code);
      end
      checks++;
      if (obs[0].len != HOLD) begin
        errors++;
        $display("FAIL single_len got %0d want %0d",
                 obs[0].len, HOLD);
      end
      checks++;
      if (obs[0].start - t0 !=
          SCAN_DIV * DEBOUNCE + 1) begin
        errors++;
        $display("FAIL single_lat got %0d want %0d",
                 obs[0].start - t0,
                 SCAN_DIV * DEBOUNCE + 1);
      end
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL single_glitch got %0d want 0",
               glitch);
    end
  endtask

  task automatic test_bounce();
    obs.delete();
    for (int i = 0; i < 10; i++) begin
      pressed[2] = (i % 2 == 0);
      tick(3);
    end
    pressed[2] = 1'b1;
    checks++;
    if (obs.size() != 0 || run != 0) begin
      errors++;
      $display("FAIL bounce_quiet got %0d want 0",
               obs.size() + run);
    end
    tick(100);
    pressed[2] = 1'b0;
    tick(60);
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL bounce_count got %0d want 1",
               obs.size());
    end else begin
      checks++;
      if (obs[0].code !== 4'h3 || obs[0].len != HOLD) begin
        errors++;
        $display("FAIL bounce_pulse got %h/%0d want 3/%0d",
                 obs[0].code, obs[0].len, HOLD);
      end
    end
  endtask

  task automatic test_busy();
    int t0;
    obs.delete();
    status = 2'b01;
    pressed[14] = 1'b1;
    tick(100);
    checks++;
    if (obs.size() != 0 || run != 0) begin
      errors++;
      $display("FAIL busy_block got %0d want 0",
               obs.size() + run);
    end
    status = 2'b00;
    t0 = cyc;
    tick(20);
    pressed[14] = 1'b0;
    tick(60);
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL busy_count got %0d want 1",
               obs.size());
    end else begin
      checks++;
      if (obs[0].code !== 4'hE || obs[0].len != HOLD) begin
        errors++;
        $display("FAIL busy_pulse got %h/%0d want e/%0d",
                 obs[0].code, obs[0].len, HOLD);
      end
      checks++;
      if (obs[0].start != t0 + 1) begin
        errors++;
        $display("FAIL busy_lat got %0d want %0d",
                 obs[0].start - t0, 1);
      end
    end
  endtask

  task automatic test_ignored();
    logic [3:0] prev;
    logic [3:0] want;
    int dwell = 0;
    int changes = 0;
    obs.delete();
    pressed[15] = 1'b1;
    tick(100);
    pressed[15] = 1'b0;
    tick(60);
    checks++;
    if (obs.size() != 0 || run != 0) begin
      errors++;
      $display("FAIL key_d got %0d want 0",
               obs.size() + run);
    end
    pressed[8] = 1'b1;
    pressed[9] = 1'b1;
    prev = rows;
    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      dwell++;
      if (rows !== prev) begin
        want = {prev[2:0], prev[3]};
        checks++;
        if (rows !== want) begin
          errors++;
          $display("FAIL scan_order got %b want %b",
                   rows, want);
        end
        if (changes > 0) begin
          checks++;
          if (dwell != SCAN_DIV) begin
            errors++;
            $display("FAIL scan_dwell got %0d want %0d",
                     dwell, SCAN_DIV);
          end
        end
        changes++;
        dwell = 0;
        prev = rows;
      end
    end
    checks++;
    if (changes < 10) begin
      errors++;
      $display("FAIL scan_moves got %0d want >=10",
               changes);
    end
    pressed[8] = 1'b0;
    pressed[9] = 1'b0;
    tick(60);
    checks++;
    if (obs.size() != 0 || run != 0) begin
      errors++;
      $display("FAIL two_col got %0d want 0",
               obs.size() + run);
    end
  endtask

  task automatic test_reset_mid_send();
    bit found = 0;
    obs.delete();
    pressed[12] = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (cmd === 4'hD) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL star_send got timeout want d");
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cmd !== 4'hF) begin
      errors++;
      $display("FAIL rst_cmd got %h want f", cmd);
    end
    checks++;
    if (rows !== 4'b1110) begin
      errors++;
      $display("FAIL rst_rows got %b want 1110", rows);
    end
    pressed[12] = 1'b0;
    tick(2);
    reset = 1'b0;
    obs.delete();
    tick(150);
    checks++;
    if (obs.size() != 0 || run != 0) begin
      errors++;
      $display("FAIL rst_resume got %0d want 0",
               obs.size() + run);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] want[$];
    obs.delete();
    glitch = 0;
    for (int k = 0; k < 16; k++) begin
      if (keymap[k] != 4'hF) want.push_back(keymap[k]);
      pressed[k] = 1'b1;
      tick($urandom_range(60, 100));
      pressed[k] = 1'b0;
      tick($urandom_range(40, 70));
    end
    checks++;
    if (obs.size() != want.size()) begin
      errors++;
      $display("FAIL sweep_count got %0d want %0d",
               obs.size(), want.size());
    end
    for (int i = 0; i < want.size(); i++) begin
      if (i < obs.size()) begin
        checks++;
        if (obs[i].code !== want[i] ||
            obs[i].len != HOLD) begin
          errors++;
          $display("FAIL sweep_%0d got %h/%0d want %h/%0d",
                   i, obs[i].code, obs[i].len,
                   want[i], HOLD);
        end
      end
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL sweep_glitch got %0d want 0", glitch);
    end
  endtask

  task automatic test_random();
    logic [3:0] want[$];
    int k;
    int busy;
    int hold;
    obs.delete();
    for (int n = 0; n < 12; n++) begin
      k = $urandom_range(0, 15);
      busy = $urandom_range(0, 30);
      hold = $urandom_range(70, 110);
      if (keymap[k] != 4'hF) want.push_back(keymap[k]);
      pressed[k] = 1'b1;
      for (int c = 0; c < hold; c++) begin
        status = (c < busy) ? 2'b01
               : 2'($urandom_range(0, 3));
        tick(1);
      end
      pressed[k] = 1'b0;
      for (int c = 0; c < 60; c++) begin
        status = 2'($urandom_range(0, 3));
        tick(1);
      end
    end
    status = 2'b00;
    tick(80);
    checks++;
    if (obs.size() != want.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d",
               obs.size(), want.size());
    end
    for (int i = 0; i < want.size(); i++) begin
      if (i < obs.size()) begin
        checks++;
        if (obs[i].code !== want[i] ||
            obs[i].len != HOLD) begin
          errors++;
          $display("FAIL rand_%0d got %h/%0d want %h/%0d",
                   i, obs[i].code, obs[i].len,
                   want[i], HOLD);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'hD, 4'h0, 4'hE, 4'hF};
    reset = 1'b1;
    pressed = '0;
    status = 2'b00;
    test_reset();
    test_single_press();
    test_bounce();
    test_busy();
    test_ignored();
    test_reset_mid_send();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
